subpel_vfilter_stream: RTL and testbench

SUBPEL_VFILTER_STREAM -- requirements
Module: subpel_vfilter_stream

---
 rtl/subpel_pkg.sv | 36 +++
 rtl/subpel_vfilter_stream_if.sv | 28 ++
 rtl/subpel_fir8.sv | 75 +++++++
 rtl/subpel_vfilter_stream.sv | 129 ++++++++++++
 tb/tb_subpel_vfilter_stream.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/subpel_pkg.sv
// Shared definitions for the vertical sub-pel interpolation stream:
// fractional-position encodings, fill-state encoding, 8-tap coefficient
// tables and the rounding constants used by every per-pixel filter.
package subpel_pkg;

  typedef enum logic [1:0] {
    FRAC_INT = 2'd0,
    FRAC_A   = 2'd1,
    FRAC_B   = 2'd2,
    FRAC_C   = 2'd3
  } frac_t;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } fill_state_t;

  localparam int N_TAPS = 8;

  // Row of the window that is passed through untouched in integer mode.
  localparam int INT_TAP = 3;

  // Quarter, half and three-quarter position taps, r0 (oldest) first.
  localparam int COEF_A [N_TAPS] = '{-1, 4, -10, 58, 17, -5, 1, 0};
  localparam int COEF_B [N_TAPS] = '{-1, 4, -11, 40, 40, -11, 4, -1};
  localparam int COEF_C [N_TAPS] = '{0, 1, -5, 17, 58, -10, 4, -1};

  // Taps sum to 64, so round-half-up is +32 then a 6-bit arithmetic shift.
  localparam int RND_OFS = 32;
  localparam int RND_SH  = 6;

  // Fill counter saturates at 7; the accept leaving 6 produces the first row.
  localparam logic [2:0] COUNT_PRE = 3'd6;
  localparam logic [2:0] COUNT_MAX = 3'd7;

endpackage

// File: rtl/subpel_vfilter_stream_if.sv
// Row-stream interface: input row handshake plus output row handshake.
// The filter block takes the slave view, the row source/sink the master view.
interface subpel_vfilter_stream_if #(
  parameter int PIX_W = 8,
  parameter int N_PIX = 8
);

  logic                     in_valid;
  logic                     in_ready;
  logic [N_PIX*PIX_W-1:0]   in_row;
  logic                     in_sof;
  logic [1:0]               frac_sel;
  logic                     out_valid;
  logic                     out_ready;
  logic [N_PIX*PIX_W-1:0]   out_row;
  logic [1:0]               out_frac;

  modport master (
    output in_valid, in_row, in_sof, frac_sel, out_ready,
    input  in_ready, out_valid, out_row, out_frac
  );

  modport slave (
    input  in_valid, in_row, in_sof, frac_sel, out_ready,
    output in_ready, out_valid, out_row, out_frac
  );

endinterface

// File: rtl/subpel_fir8.sv
// One output pixel of the vertical interpolator: 8-tap shift-add FIR over a
// column of the row window, followed by rounding and clipping to pixel range.
// Purely combinational; the fractional position selects the tap set.
module subpel_fir8
  import subpel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int ACC_W = PIX_W + 8
) (
  input  logic [PIX_W-1:0] taps [N_TAPS],
  input  frac_t            frac,
  output logic [PIX_W-1:0] pix
);

  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);
  localparam logic signed [ACC_W-1:0] RND_ADD = ACC_W'(RND_OFS);

  logic signed [ACC_W-1:0] tap_ext;
  logic signed [ACC_W-1:0] sum_a;
  logic signed [ACC_W-1:0] sum_b;
  logic signed [ACC_W-1:0] sum_c;
  logic signed [ACC_W-1:0] sum_sel;
  logic signed [ACC_W-1:0] rnd;

  // Constant-coefficient product built from shifted copies of x, one per set
  // bit of |c|; with constant c this collapses to a small adder tree.
  function automatic logic signed [ACC_W-1:0] cmul(
    input logic signed [ACC_W-1:0] x,
    input int                      c
  );
    logic signed [ACC_W-1:0] acc;
    int                      mag;
    acc = '0;
    mag = (c < 0) ? -c : c;
    for (int b = 0; b < 7; b++) begin
      if (mag[b]) acc = acc + (x <<< b);
    end
    return (c < 0) ? -acc : acc;
  endfunction

  // Accumulate all three tap sets in parallel, then pick the requested one.
  always_comb begin
    tap_ext = '0;
    sum_a   = '0;
    sum_b   = '0;
    sum_c   = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      tap_ext = $signed({{(ACC_W-PIX_W){1'b0}}, taps[k]});
      sum_a   = sum_a + cmul(tap_ext, COEF_A[k]);
      sum_b   = sum_b + cmul(tap_ext, COEF_B[k]);
      sum_c   = sum_c + cmul(tap_ext, COEF_C[k]);
    end
    case (frac)
      FRAC_A:  sum_sel = sum_a;
      FRAC_B:  sum_sel = sum_b;
      FRAC_C:  sum_sel = sum_c;
      default: sum_sel = '0;
    endcase
  end

  // Round half up, then clip to the unsigned pixel range; integer mode bypasses.
  always_comb begin
    rnd = (sum_sel + RND_ADD) >>> RND_SH;
    if (frac == FRAC_INT) begin
      pix = taps[INT_TAP];
    end else if (rnd < 0) begin
      pix = '0;
    end else if (rnd > PIX_MAX) begin
      pix = '1;
    end else begin
      pix = rnd[PIX_W-1:0];
    end
  end

endmodule

// File: rtl/subpel_vfilter_stream.sv
// Streaming vertical sub-pel interpolator. Keeps an 8-row window of integer
// pixel rows and, once the window is full, emits one filtered row per
// accepted input row through a single-entry output register.
module subpel_vfilter_stream
  import subpel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int N_PIX = 8,
  parameter int ACC_W = PIX_W + 8
) (
  input  logic                  clk,
  input  logic                  rst,
  subpel_vfilter_stream_if.slave bus
);

  localparam int ROW_W = N_PIX * PIX_W;

  logic [ROW_W-1:0] win_q [N_TAPS];
  logic [ROW_W-1:0] win_d [N_TAPS];
  logic [2:0]       count_q;
  logic [2:0]       count_d;
  logic             fresh_q;
  logic             fresh_d;
  logic             out_valid_q;
  logic             out_valid_d;
  logic [ROW_W-1:0] out_row_q;
  logic [ROW_W-1:0] out_row_d;
  frac_t            out_frac_q;
  frac_t            out_frac_d;

  fill_state_t      state;
  frac_t            frac_in;
  logic             in_ready;
  logic             accept;
  logic             restart;
  logic             produce;
  logic [ROW_W-1:0] fir_row;

  // Registered state; reset empties the window and drops any pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_TAPS; k++) win_q[k] <= '0;
      count_q     <= '0;
      fresh_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_frac_q  <= FRAC_INT;
    end else begin
      for (int k = 0; k < N_TAPS; k++) win_q[k] <= win_d[k];
      count_q     <= count_d;
      fresh_q     <= fresh_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_frac_q  <= out_frac_d;
    end
  end

  // Handshake: the output register frees up when it is empty or being drained.
  always_comb begin
    state    = (count_q == COUNT_MAX) ? ST_RUN : ST_FILL;
    frac_in  = frac_t'(bus.frac_sel);
    in_ready = !out_valid_q || bus.out_ready;
    accept   = bus.in_valid && in_ready;
  end

  // Window shift and fill count; a start-of-block row (or the first row after
  // reset) restarts the window with only the new row in it.
  always_comb begin
    for (int k = 0; k < N_TAPS; k++) win_d[k] = win_q[k];
    count_d = count_q;
    fresh_d = fresh_q;
    restart = accept && (bus.in_sof || fresh_q);
    produce = 1'b0;
    if (accept) begin
      fresh_d = 1'b0;
      if (restart) begin
        for (int k = 0; k < N_TAPS; k++) win_d[k] = '0;
        win_d[N_TAPS-1] = bus.in_row;
        count_d         = '0;
      end else begin
        for (int k = 0; k < N_TAPS - 1; k++) win_d[k] = win_q[k+1];
        win_d[N_TAPS-1] = bus.in_row;
        if (state == ST_FILL) count_d = count_q + 3'd1;
        produce = (state == ST_RUN) || (count_q == COUNT_PRE);
      end
    end
  end

  // Output register: a new result overwrites, a drain without one empties it.
  always_comb begin
    out_valid_d = out_valid_q;
    out_row_d   = out_row_q;
    out_frac_d  = out_frac_q;
    if (produce) begin
      out_valid_d = 1'b1;
      out_row_d   = fir_row;
      out_frac_d  = frac_in;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Drive the interface outputs straight from the registers.
  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = out_valid_q;
    bus.out_row   = out_row_q;
    bus.out_frac  = out_frac_q;
  end

  for (genvar p = 0; p < N_PIX; p++) begin : g_pix
    logic [PIX_W-1:0] taps [N_TAPS];

    // Gather one pixel column from the updated window.
    always_comb begin
      for (int k = 0; k < N_TAPS; k++) taps[k] = win_d[k][p*PIX_W +: PIX_W];
    end

    subpel_fir8 #(
      .PIX_W (PIX_W),
      .ACC_W (ACC_W)
    ) u_fir (
      .taps (taps),
      .frac (frac_in),
      .pix  (fir_row[p*PIX_W +: PIX_W])
    );
  end

endmodule

// File: tb/tb_subpel_vfilter_stream.sv
// Directed bench for the vertical sub-pel interpolator: reset state, the four
// filter positions on hand-computed windows, clipping, backpressure, block
// restart and asynchronous reset mid-block.
module tb_subpel_vfilter_stream;

  typedef logic [63:0] row_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  subpel_vfilter_stream_if #(.PIX_W(8), .N_PIX(8)) bus ();

  subpel_vfilter_stream #(
    .PIX_W (8),
    .N_PIX (8),
    .ACC_W (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  function automatic row_t fill(input logic [7:0] v);
    return {8{v}};
  endfunction

  function automatic row_t ramp(input int base);
    row_t r;
    for (int p = 0; p < 8; p++) r[p*8 +: 8] = 8'(base + p);
    return r;
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input row_t exp_row, input logic [1:0] exp_frac);
    checkVal({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    checkVal({tag, "_row"}, bus.out_row, exp_row);
    checkVal({tag, "_frac"}, 64'(bus.out_frac), 64'(exp_frac));
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  // Present one row and hold it until the block accepts it (bounded wait).
  task automatic applyStimulus(input row_t row, input logic sof, input logic [1:0] frac);
    int guard;
    bus.in_valid = 1'b1;
    bus.in_row   = row;
    bus.in_sof   = sof;
    bus.frac_sel = frac;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready stayed %b, required 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  // Hard stop in case something stalls outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_row    = '0;
    bus.in_sof    = 1'b0;
    bus.frac_sel  = 2'd0;
    bus.out_ready = 1'b1;

    #12;
    checkVal("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkVal("rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkVal("rst_out_row", bus.out_row, 64'd0);
    checkVal("rst_out_frac", 64'(bus.out_frac), 64'd0);
    #1 rst = 1'b0;
    idleCycle();

    // Constant rows, half-pel: exactly one row of 100s.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(fill(8'd100), i == 0, 2'd2);
      checkVal("const_fill_quiet", 64'(bus.out_valid), 64'd0);
    end
    applyStimulus(fill(8'd100), 1'b0, 2'd2);
    checkOutput("const_b", fill(8'd100), 2'd2);
    idleCycle();
    checkVal("const_single", 64'(bus.out_valid), 64'd0);

    // Step edge 0 -> 255 between r3 and r4, half-pel: 128.
    for (int i = 0; i < 8; i++) applyStimulus((i < 4) ? fill(8'd0) : fill(8'd255), i == 0, 2'd2);
    checkOutput("step_b", fill(8'd128), 2'd2);

    // Same step, quarter-pel: 3315 -> 52.
    for (int i = 0; i < 8; i++) applyStimulus((i < 4) ? fill(8'd0) : fill(8'd255), i == 0, 2'd1);
    checkOutput("step_a", fill(8'd52), 2'd1);

    // Positive overflow clips to 255 (sum 20400).
    for (int i = 0; i < 8; i++)
      applyStimulus((i == 3 || i == 4) ? fill(8'd255) : fill(8'd0), i == 0, 2'd2);
    checkOutput("clip_high", fill(8'd255), 2'd2);

    // Negative sum clips to 0 (sum -5610).
    for (int i = 0; i < 8; i++)
      applyStimulus((i == 2 || i == 5) ? fill(8'd255) : fill(8'd0), i == 0, 2'd2);
    checkOutput("clip_low", fill(8'd0), 2'd2);

    // Per-lane ramp (row i, lane p = 8i+p): integer passes r3, then the
    // position changes row by row without flushing the window.
    for (int i = 0; i < 8; i++) applyStimulus(ramp(8 * i), i == 0, 2'd0);
    checkOutput("ramp_int", ramp(24), 2'd0);
    applyStimulus(ramp(64), 1'b0, 2'd2);
    checkOutput("ramp_b", ramp(36), 2'd2);
    applyStimulus(ramp(72), 1'b0, 2'd1);
    checkOutput("ramp_a", ramp(42), 2'd1);
    applyStimulus(ramp(80), 1'b0, 2'd3);
    checkOutput("ramp_c", ramp(54), 2'd3);

    // Backpressure: rows of 10i+1 in integer mode, sink stalls 3 cycles.
    for (int i = 0; i < 8; i++) applyStimulus(fill(8'(10 * i + 1)), i == 0, 2'd0);
    checkOutput("bp_first", fill(8'd31), 2'd0);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_row    = fill(8'd81);
    bus.in_sof    = 1'b0;
    bus.frac_sel  = 2'd0;
    for (int s = 0; s < 3; s++) begin
      #1;
      checkVal("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
      checkOutput("bp_hold", fill(8'd31), 2'd0);
      @(posedge clk);
    end
    #1;
    bus.out_ready = 1'b1;
    #1;
    checkVal("bp_in_ready_high", 64'(bus.in_ready), 64'd1);
    idleCycle();
    bus.in_valid = 1'b0;
    checkOutput("bp_second", fill(8'd41), 2'd0);
    applyStimulus(fill(8'd91), 1'b0, 2'd0);
    checkOutput("bp_third", fill(8'd51), 2'd0);
    idleCycle();
    checkVal("bp_drained", 64'(bus.out_valid), 64'd0);

    // Start-of-block on row 10 restarts filling; output resumes on row 17.
    for (int i = 1; i <= 9; i++) applyStimulus(fill(8'd100), i == 1, 2'd2);
    checkOutput("sof_before", fill(8'd100), 2'd2);
    for (int i = 10; i <= 16; i++) begin
      applyStimulus(fill(8'd200), i == 10, 2'd2);
      checkVal("sof_refill_quiet", 64'(bus.out_valid), 64'd0);
    end
    applyStimulus(fill(8'd200), 1'b0, 2'd2);
    checkOutput("sof_resume", fill(8'd200), 2'd2);

    // Asynchronous reset with a result pending, then a full refill.
    #2 rst = 1'b1;
    #1;
    checkVal("arst_out_valid", 64'(bus.out_valid), 64'd0);
    checkVal("arst_in_ready", 64'(bus.in_ready), 64'd1);
    #1 rst = 1'b0;
    for (int i = 0; i < 7; i++) applyStimulus(fill(8'd50), 1'b0, 2'd2);
    checkVal("arst_refill_quiet", 64'(bus.out_valid), 64'd0);
    applyStimulus(fill(8'd50), 1'b0, 2'd2);
    checkOutput("arst_refill", fill(8'd50), 2'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
